fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Pipeline control unit that sequences the Y86-64 fetch stage.
- Owns the predicted-PC register (F_predPC) and drives the fetch PC, choosing between the predicted PC, a mispredicted-branch fallthrough and a ret target.
- Generates stall/bubble controls for the F/D/E/M/W pipeline registers (load-use, ret, mispredict, exceptions).
- Holds the run/halt/fault state of the processor.

Parameters:
- RESET_PC, 64'h0, fetch address loaded into F_predPC on reset.
- ADDR_W, 64, PC/data width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- predPC_i  in  ADDR_W  predicted next PC from fetch stage
- e_Cnd_i  in  1  branch condition computed in execute
- D_icode_i, E_icode_i, M_icode_i, W_icode_i  in  4 each  icode held in D/E/M/W registers
- E_dstM_i  in  4  load destination register in E
- d_srcA_i, d_srcB_i  in  4 each  source registers decoded in D
- M_valA_i  in  ADDR_W  fallthrough PC carried by a jXX in M
- W_valM_i  in  ADDR_W  ret target read by memory, held in W
- m_stat_i, W_stat_i  in  3 each  status of the memory stage / W register
- PC_o  out  ADDR_W  fetch address (drives fetch PC_i)
- F_stall_o, D_stall_o, W_stall_o  out  1 each  hold register
- D_bubble_o, E_bubble_o, M_bubble_o  out  1 each  load nop into register
- set_cc_o  out  1  condition-code write enable
- stat_o  out  3  processor status (registered)
- halted_o  out  1  processor stopped (HALT or FAULT)

Behaviour:
- PC select (combinational):
  - if M_icode==IJXX && !M_Cnd, then PC_o=M_valA_i;
  - else if W_icode==IRET, then PC_o=W_valM_i;
  - else PC_o=F_predPC.
  - M_Cnd is e_Cnd_i registered alongside E→M; the register clears when M_bubble_o or reset is asserted.
- Hazard terms:
  - load_use = E_icode∈{IMRMOVQ,IPOPQ} && E_dstM!=4'hF && E_dstM∈{d_srcA,d_srcB}
  - ret_busy = IRET∈{D,E,M}_icode
  - mispred = E_icode==IJXX && !e_Cnd_i
- Stall/bubble controls in state RUN:
  - F_stall = load_use|ret_busy
  - D_stall = load_use
  - D_bubble = mispred | (!load_use & ret_busy)
  - E_bubble = mispred | load_use
  - exc = (m_stat!=SAOK)|(W_stat!=SAOK)
  - M_bubble = exc
  - W_stall = W_stat!=SAOK
  - set_cc = E_icode==IOPQ & !exc
- Simultaneous events:
  - mispredict in E with ret in D: F stalls, D and E bubble. The next cycle fetches from M_valA.
  - load_use with ret: the load-use action wins for D, so D_stall=1 and D_bubble=0.
- F_predPC register:
  - reset gives RESET_PC.
  - in RUN with !F_stall, it loads predPC_i.
  - otherwise it holds.
- FSM states:
  - RUN. W_stat==SHLT moves to HALT. W_stat∈{SADR,SINS} moves to FAULT.
  - HALT and FAULT are absorbing until reset.
  - In HALT/FAULT: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0.
- stat_o:
  - registered. Reset gives SAOK. It takes W_stat on the RUN exit transition, then freezes.
- halted_o is registered; it is 1 in HALT/FAULT and 0 on reset.
- During reset (rst_n_i=0):
  - D_bubble=E_bubble=M_bubble=1.
  - all stalls 0, set_cc 0, PC_o=RESET_PC.
  - Reset asserted mid-stall or in FAULT forces return to RUN on the next edge.
- Width rules:
  - all PC arithmetic is done by fetch; this block only selects and holds.
  - no wrap handling is required beyond ADDR_W truncation.

Optional Feature:
- Macro: FETCH_CTRL_PERF_CNT_EN.
- When defined, adds three 32-bit output ports:
  - cycle_cnt_o counts RUN cycles.
  - stall_cnt_o counts cycles with F_stall in RUN.
  - mispred_cnt_o counts cycles with mispred in RUN.
- The counters clear on reset, saturate at 32'hFFFFFFFF and freeze outside RUN.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Decomposition:
- Icode constants (IJXX, IRET, IMRMOVQ, IPOPQ, IOPQ), status codes (SAOK, SHLT, SADR, SINS) and RNONE=4'hF come from the shared define file.
- The FSM state encodings are added to the same define file.
- One combinational sub-module, hazard_unit, computes load_use, ret_busy, mispred and the raw stall/bubble vectors.
- fetch_ctrl adds the FSM, the F_predPC and M_Cnd registers, and the PC mux.

Test Plan:
- Reset release with RESET_PC=64'h100 → PC_o=64'h100 and stat_o=SAOK. After one cycle with predPC_i=64'h10A, PC_o=64'h10A.
- E_icode=IMRMOVQ, E_dstM=4'h3, d_srcA=4'h3 → F_stall=D_stall=E_bubble=1, D_bubble=0, and F_predPC held.
- E_icode=IJXX, e_Cnd=0 → D_bubble=E_bubble=1. Next cycle with M_valA=64'h2C, PC_o=64'h2C.
- IRET walks D→E→M → F_stall and D_bubble asserted for 3 cycles. When W_icode=IRET with W_valM=64'h40, PC_o=64'h40.
- Mispredict in E plus ret in D in the same cycle → F_stall=D_bubble=E_bubble=1. Next cycle PC_o=M_valA.
- W_stat=SADR → the next edge gives halted_o=1 and stat_o=SADR. All stalls stay high and set_cc=0 until rst_n_i=0, which restores RUN and SAOK.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - Y86-64 icode/status constants, FSM states and control bundle for fetch_ctrl
package fetch_ctrl_pkg;

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;
    logic set_cc;
  } ctrl_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_hazard_unit.sv
// rtl/fetch_ctrl_hazard_unit.sv - combinational load-use/ret/mispredict detection and raw RUN-state controls
module fetch_ctrl_hazard_unit
  import fetch_ctrl_pkg::*;
(
  input  logic [3:0] D_icode_i,
  input  logic [3:0] E_icode_i,
  input  logic [3:0] M_icode_i,
  input  logic [3:0] E_dstM_i,
  input  logic [3:0] d_srcA_i,
  input  logic [3:0] d_srcB_i,
  input  logic       e_Cnd_i,
  input  logic [2:0] m_stat_i,
  input  logic [2:0] W_stat_i,
  output logic       mispred_o,
  output ctrl_t      ctrl_o
);

  logic w_load_use;
  logic w_ret_busy;
  logic w_exc;

  assign w_load_use = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                      (E_dstM_i != RNONE) &&
                      ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign w_ret_busy = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
  assign mispred_o  = (E_icode_i == IJXX) && !e_Cnd_i;
  assign w_exc      = (m_stat_i != SAOK) || (W_stat_i != SAOK);

  // A load-use stall in D takes priority over the ret bubble.
  always_comb begin
    ctrl_o          = '0;
    ctrl_o.f_stall  = w_load_use | w_ret_busy;
    ctrl_o.d_stall  = w_load_use;
    ctrl_o.d_bubble = mispred_o | (!w_load_use & w_ret_busy);
    ctrl_o.e_bubble = mispred_o | w_load_use;
    ctrl_o.m_bubble = w_exc;
    ctrl_o.w_stall  = (W_stat_i != SAOK);
    ctrl_o.set_cc   = (E_icode_i == IOPQ) & !w_exc;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - Y86-64 fetch sequencing: PC select, pipeline stall/bubble, run/halt/fault FSM
// Optional FETCH_CTRL_PERF_CNT_EN adds saturating cycle/stall/mispredict counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] predPC_i,
  input  logic              e_Cnd_i,
  input  logic [3:0]        D_icode_i,
  input  logic [3:0]        E_icode_i,
  input  logic [3:0]        M_icode_i,
  input  logic [3:0]        W_icode_i,
  input  logic [3:0]        E_dstM_i,
  input  logic [3:0]        d_srcA_i,
  input  logic [3:0]        d_srcB_i,
  input  logic [ADDR_W-1:0] M_valA_i,
  input  logic [ADDR_W-1:0] W_valM_i,
  input  logic [2:0]        m_stat_i,
  input  logic [2:0]        W_stat_i,
  output logic [ADDR_W-1:0] PC_o,
  output logic              F_stall_o,
  output logic              D_stall_o,
  output logic              W_stall_o,
  output logic              D_bubble_o,
  output logic              E_bubble_o,
  output logic              M_bubble_o,
  output logic              set_cc_o,
  output logic [2:0]        stat_o,
  output logic              halted_o
`ifdef FETCH_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       mispred_cnt_o
`endif
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_pred_pc;
  logic              r_m_cnd;
  logic [2:0]        r_stat;
  logic              r_halted;
  logic              w_mispred;
  ctrl_t             w_raw;

  fetch_ctrl_hazard_unit u_hazard (
    .D_icode_i (D_icode_i),
    .E_icode_i (E_icode_i),
    .M_icode_i (M_icode_i),
    .E_dstM_i  (E_dstM_i),
    .d_srcA_i  (d_srcA_i),
    .d_srcB_i  (d_srcB_i),
    .e_Cnd_i   (e_Cnd_i),
    .m_stat_i  (m_stat_i),
    .W_stat_i  (W_stat_i),
    .mispred_o (w_mispred),
    .ctrl_o    (w_raw)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN) begin
      if (W_stat_i == SHLT)
        w_state_nxt = ST_HALT;
      else if ((W_stat_i == SADR) || (W_stat_i == SINS))
        w_state_nxt = ST_FAULT;
    end
  end

  // Reset overrides everything: bubble D/E/M, no stalls, fetch from RESET_PC.
  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    W_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    set_cc_o   = 1'b0;
    if (!rst_n_i) begin
      D_bubble_o = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
    end else if (r_state == ST_RUN) begin
      F_stall_o  = w_raw.f_stall;
      D_stall_o  = w_raw.d_stall;
      W_stall_o  = w_raw.w_stall;
      D_bubble_o = w_raw.d_bubble;
      E_bubble_o = w_raw.e_bubble;
      M_bubble_o = w_raw.m_bubble;
      set_cc_o   = w_raw.set_cc;
    end else begin
      F_stall_o  = 1'b1;
      D_stall_o  = 1'b1;
      W_stall_o  = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
    end
  end

  always_comb begin
    PC_o = r_pred_pc;
    if (!rst_n_i)
      PC_o = RESET_PC;
    else if ((M_icode_i == IJXX) && !r_m_cnd)
      PC_o = M_valA_i;
    else if (W_icode_i == IRET)
      PC_o = W_valM_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_RUN;
      r_pred_pc <= RESET_PC;
      r_m_cnd   <= 1'b0;
      r_stat    <= SAOK;
      r_halted  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_m_cnd  <= M_bubble_o ? 1'b0 : e_Cnd_i;
      r_halted <= (w_state_nxt != ST_RUN);
      if ((r_state == ST_RUN) && !F_stall_o)
        r_pred_pc <= predPC_i;
      if ((r_state == ST_RUN) && (w_state_nxt != ST_RUN))
        r_stat <= W_stat_i;
    end
  end

  assign stat_o   = r_stat;
  assign halted_o = r_halted;

`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_mispred_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cycle_cnt   <= '0;
      r_stall_cnt   <= '0;
      r_mispred_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_cycle_cnt <= sat_inc(r_cycle_cnt);
      if (F_stall_o)
        r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_mispred)
        r_mispred_cnt <= sat_inc(r_mispred_cnt);
    end
  end

  assign cycle_cnt_o   = r_cycle_cnt;
  assign stall_cnt_o   = r_stall_cnt;
  assign mispred_cnt_o = r_mispred_cnt;
`else
  logic w_unused_mispred;
  assign w_unused_mispred = w_mispred;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed table and sequence bench for fetch_ctrl
module tb_fetch_ctrl;

  localparam logic [3:0] NOP = 4'h1, MRM = 4'h5, OPQ = 4'h6, JXX = 4'h7, RET = 4'h9, POP = 4'hB, RN = 4'hF;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pred_pc, m_vala, w_valm, pc;
  logic        e_cnd;
  logic [3:0]  d_ic, e_ic, m_ic, w_ic, e_dstm, srca, srcb;
  logic [2:0]  m_stat, w_stat, stat;
  logic        f_st, d_st, w_st, d_bb, e_bb, m_bb, set_cc, halted;
`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt, stl_cnt, mis_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(64), .RESET_PC(64'h100)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .predPC_i(pred_pc), .e_Cnd_i(e_cnd),
    .D_icode_i(d_ic), .E_icode_i(e_ic), .M_icode_i(m_ic), .W_icode_i(w_ic),
    .E_dstM_i(e_dstm), .d_srcA_i(srca), .d_srcB_i(srcb),
    .M_valA_i(m_vala), .W_valM_i(w_valm), .m_stat_i(m_stat), .W_stat_i(w_stat),
    .PC_o(pc), .F_stall_o(f_st), .D_stall_o(d_st), .W_stall_o(w_st),
    .D_bubble_o(d_bb), .E_bubble_o(e_bb), .M_bubble_o(m_bb),
    .set_cc_o(set_cc), .stat_o(stat), .halted_o(halted)
`ifdef FETCH_CTRL_PERF_CNT_EN
    , .cycle_cnt_o(cyc_cnt), .stall_cnt_o(stl_cnt), .mispred_cnt_o(mis_cnt)
`endif
  );

  typedef struct {
    logic [3:0] d, e, m, w, dstm, sa, sb;
    logic       cnd;
    logic [2:0] ms, ws;
    logic [6:0] exp;  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {f_st, d_st, d_bb, e_bb, m_bb, w_st, set_cc};
  endfunction

  task automatic idle();
    d_ic = NOP; e_ic = NOP; m_ic = NOP; w_ic = NOP;
    e_dstm = RN; srca = RN; srcb = RN; e_cnd = 1'b0;
    m_stat = AOK; w_stat = AOK;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{NOP, NOP, NOP, NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 7'b0000000};
    vecs[1]  = '{NOP, MRM, NOP, NOP, 4'h3, 4'h3, RN,   1'b0, AOK, AOK, 7'b1101000};
    vecs[2]  = '{NOP, POP, NOP, NOP, 4'h5, RN,   4'h5, 1'b0, AOK, AOK, 7'b1101000};
    vecs[3]  = '{NOP, MRM, NOP, NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 7'b0000000};
    vecs[4]  = '{NOP, MRM, NOP, NOP, 4'h3, 4'h4, 4'h5, 1'b0, AOK, AOK, 7'b0000000};
    vecs[5]  = '{NOP, JXX, NOP, NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 7'b0011000};
    vecs[6]  = '{NOP, JXX, NOP, NOP, RN,   RN,   RN,   1'b1, AOK, AOK, 7'b0000000};
    vecs[7]  = '{RET, NOP, NOP, NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 7'b1010000};
    vecs[8]  = '{NOP, RET, NOP, NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 7'b1010000};
    vecs[9]  = '{NOP, NOP, RET, NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 7'b1010000};
    vecs[10] = '{RET, JXX, NOP, NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 7'b1011000};
    vecs[11] = '{RET, MRM, NOP, NOP, 4'h3, 4'h3, RN,   1'b0, AOK, AOK, 7'b1101000};
    vecs[12] = '{NOP, OPQ, NOP, NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 7'b0000001};
    vecs[13] = '{NOP, OPQ, NOP, NOP, RN,   RN,   RN,   1'b0, ADR, AOK, 7'b0000100};
    vecs[14] = '{NOP, OPQ, NOP, NOP, RN,   RN,   RN,   1'b0, AOK, INS, 7'b0000110};

    // Reset state, with an OPQ in E that must not write CCs.
    rst_n = 1'b0; idle(); e_ic = OPQ;
    pred_pc = 64'h0; m_vala = 64'h0; w_valm = 64'h0;
    cyc(); cyc(); #1;
    chk("rst_ctl", ctl(), 7'b0011100);
    chk("rst_pc", pc, 64'h100);
    chk("rst_stat", stat, AOK);
    chk("rst_halted", halted, 1'b0);

    rst_n = 1'b1; idle(); pred_pc = 64'h10A; #1;
    chk("rel_pc", pc, 64'h100);
    cyc(); #1;
    chk("pred_load", pc, 64'h10A);

    // Table: combinational controls in RUN, restored to idle before each edge.
    for (int i = 0; i < 15; i++) begin
      cyc();
      d_ic = vecs[i].d; e_ic = vecs[i].e; m_ic = vecs[i].m; w_ic = vecs[i].w;
      e_dstm = vecs[i].dstm; srca = vecs[i].sa; srcb = vecs[i].sb;
      e_cnd = vecs[i].cnd; m_stat = vecs[i].ms; w_stat = vecs[i].ws;
      #1;
      chk($sformatf("vec%0d", i), ctl(), vecs[i].exp);
      idle();
    end
    cyc(); #1;
    chk("after_tbl_pc", pc, 64'h10A);

    // Load-use holds F_predPC, then releases.
    pred_pc = 64'h200; e_ic = MRM; e_dstm = 4'h3; srca = 4'h3;
    cyc(); #1;
    chk("lu_hold", pc, 64'h10A);
    idle();
    cyc(); #1;
    chk("lu_release", pc, 64'h200);

    // Mispredict: next cycle fetches M_valA.
    e_ic = JXX; e_cnd = 1'b0; #1;
    chk("mp_ctl", ctl(), 7'b0011000);
    cyc(); idle(); m_ic = JXX; m_vala = 64'h2C; #1;
    chk("mp_pc", pc, 64'h2C);
    // Taken branch: M_valA must be ignored.
    idle(); e_ic = JXX; e_cnd = 1'b1;
    cyc(); idle(); m_ic = JXX; #1;
    chk("tk_pc", pc, 64'h200);
    idle();

    // ret walking D -> E -> M -> W.
    pred_pc = 64'h300;
    d_ic = RET; #1;
    chk("ret_d", ctl(), 7'b1010000);
    cyc(); d_ic = NOP; e_ic = RET; #1;
    chk("ret_e", ctl(), 7'b1010000);
    cyc(); e_ic = NOP; m_ic = RET; #1;
    chk("ret_m", ctl(), 7'b1010000);
    chk("ret_hold_pc", pc, 64'h200);
    cyc(); m_ic = NOP; w_ic = RET; w_valm = 64'h40; #1;
    chk("ret_w_ctl", ctl(), 7'b0000000);
    chk("ret_w_pc", pc, 64'h40);
    idle();

    // Mispredict in E with ret in D.
    cyc(); d_ic = RET; e_ic = JXX; e_cnd = 1'b0; #1;
    chk("mpret_ctl", ctl(), 7'b1011000);
    cyc(); idle(); d_ic = RET; m_ic = JXX; m_vala = 64'h58; #1;
    chk("mpret_pc", pc, 64'h58);
    idle();

    // Fault via SADR in W.
    cyc(); w_stat = ADR; #1;
    chk("flt_run_ctl", ctl(), 7'b0000110);
    cyc(); w_stat = AOK; e_ic = OPQ; pred_pc = 64'h999; #1;
    chk("flt_halted", halted, 1'b1);
    chk("flt_stat", stat, ADR);
    chk("flt_ctl", ctl(), 7'b1101110);
    cyc(); #1;
    chk("flt_ctl2", ctl(), 7'b1101110);
    chk("flt_stat2", stat, ADR);
    chk("flt_pc_hold", pc, 64'h300);
    rst_n = 1'b0; idle();
    cyc(); rst_n = 1'b1; #1;
    chk("flt_rst_halted", halted, 1'b0);
    chk("flt_rst_stat", stat, AOK);
    chk("flt_rst_pc", pc, 64'h100);

    // HALT via SHLT, then reset.
    w_stat = HLT;
    cyc(); w_stat = AOK; #1;
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_stat", stat, HLT);
    chk("hlt_ctl", ctl(), 7'b1101110);
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1; #1;
    chk("hlt_rst_stat", stat, AOK);
    chk("hlt_rst_ctl", ctl(), 7'b0000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
